cv32e40x_wb_scoreboard: RTL and testbench
=========================================

Name: cv32e40x_wb_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the controller. It supersedes purely combinational bypass/stall decisions for long-latency writers, such as offloaded eXtension instructions and multi-cycle units.
- Tracks up to MAX_OUTSTANDING issued-but-unwritten register writes, each tagged by an ID.
- Raises RAW/WAW stall to the ID stage for any of REGFILE_NUM_READ_PORTS read ports.
- Handles commit/kill and bulk flush.

Parameters:
- REGFILE_NUM_READ_PORTS, 2, number of ID read ports checked for RAW.
- MAX_OUTSTANDING, 4, table entries (1..16).
- ID_WIDTH, 4, instruction ID tag width.
- RF_ADDR_WIDTH, 5, register address width.

Ports:
- clk  input  1  gated clock
- rst_n  input  1  asynchronous active-low reset
- issue_valid_i  input  1  instruction leaving EX toward long-latency unit this cycle
- issue_id_i  input  ID_WIDTH  tag of issued instruction
- issue_we_i  input  1  issued instruction writes rd
- issue_rd_i  input  RF_ADDR_WIDTH  destination register
- issue_ready_o  output  1  free entry available
- commit_valid_i  input  1  commit decision for one ID
- commit_id_i  input  ID_WIDTH  ID being committed/killed
- commit_kill_i  input  1  1 = kill (entry freed), 0 = commit
- result_valid_i  input  1  result written to RF this cycle
- result_id_i  input  ID_WIDTH  ID of result
- flush_i  input  1  kill all uncommitted entries
- rf_re_id_i  input  REGFILE_NUM_READ_PORTS  read-enable per port in ID
- rf_raddr_id_i  input  REGFILE_NUM_READ_PORTS*RF_ADDR_WIDTH  read addresses in ID, port p at [p*W +: W]
- rf_we_id_i  input  1  ID instruction writes rd
- rd_id_i  input  RF_ADDR_WIDTH  ID destination
- stall_raw_o  output  1  RAW hazard on any port
- stall_waw_o  output  1  WAW hazard
- outstanding_cnt_o  output  $clog2(MAX_OUTSTANDING+1)  valid entries
- empty_o  output  1  no valid entries

Behaviour:

Reset and table contents:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: all entries invalid, entries cleared to 0, issue_ready_o=1, stall_*=0, outstanding_cnt_o=0, empty_o=1.
- Entry fields: valid, id, we, rd, committed.

Issue:
- When issue_valid_i && issue_ready_o, the lowest-index free entry is loaded (valid=1, committed=0) at the clock edge.
- issue_ready_o = not all entries valid, computed from registered state only. An entry freed in the same cycle does not make room until the next cycle.
- issue_valid_i while !issue_ready_o is ignored (assertion).
- Issuing an ID already valid in the table is illegal (assertion).

Result, commit and kill:
- result_valid_i frees the valid entry with matching id at the edge. No match means no change (assertion).
- commit_valid_i && !commit_kill_i sets committed on the matching entry.
- commit_valid_i && commit_kill_i frees the matching entry.
- flush_i frees every entry with committed=0 at the edge. Committed entries survive and await their result.

Simultaneous events:
- Priority per entry: free (result, kill, flush) over commit-set.
- Issue writes a different entry than any being freed; there are no same-entry collisions.
- issue plus flush in the same cycle: the issued instruction is also flushed (not allocated).
- result and commit on the same ID in the same cycle: the entry is freed.

Hazards (combinational):
- An entry hits when valid && we && rd != 0 && rd == addr.
- An in-flight issue also hits when issue_valid_i && issue_we_i && issue_rd_i != 0 && issue_rd_i == addr && !flush_i.
- stall_raw_o = OR over ports p with rf_re_id_i[p] of hit(rf_raddr_id_i[p]).
- stall_waw_o = rf_we_id_i && hit(rd_id_i).
- A result in cycle N still stalls in cycle N; the stall releases in N+1, when the RF holds the value.
- Register x0 never causes a stall.

Counters:
- outstanding_cnt_o and empty_o reflect registered state.

Test Plan:
- Reset -> issue_ready_o=1, empty_o=1, outstanding_cnt_o=0, stall_raw_o=0, stall_waw_o=0.
- Issue id=3 rd=x5; the same cycle ID reads x5 on port 1 -> stall_raw_o=1 (issue bypass). It stays 1 until result id=3 in cycle N; 0 in N+1; cnt returns 0.
- Issue 4 IDs (MAX_OUTSTANDING=4) -> issue_ready_o=0, cnt=4. Result on one plus issue in the same cycle -> the issue is ignored; issue_ready_o=1 the next cycle.
- Issue ids 1,2 (rd x6,x7); commit id 1; flush_i -> id 2 freed, id 1 kept, cnt=1; ID rd=x6 -> stall_waw_o=1.
- Commit_kill id=2 -> entry freed next cycle, x7 no longer stalls; issue rd=x0 with we=1 -> no stall on x0 reads.
- Assert rst_n low with 3 entries valid mid-operation -> all outputs at reset values immediately (asynchronous).

Source files
------------

// File: rtl/cv32e40x_wb_scoreboard.sv
// Register-hazard scoreboard for long-latency writers: tracks issued-but-unwritten rd writes by ID
// and raises RAW/WAW stalls to ID. Table updates land at the clock edge; stalls are combinational.
module cv32e40x_wb_scoreboard #(
   parameter int REGFILE_NUM_READ_PORTS = 2,
   parameter int MAX_OUTSTANDING        = 4,
   parameter int ID_WIDTH               = 4,
   parameter int RF_ADDR_WIDTH          = 5
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        issue_valid_i,
   input  logic [ID_WIDTH-1:0]                         issue_id_i,
   input  logic                                        issue_we_i,
   input  logic [RF_ADDR_WIDTH-1:0]                    issue_rd_i,
   output logic                                        issue_ready_o,
   input  logic                                        commit_valid_i,
   input  logic [ID_WIDTH-1:0]                         commit_id_i,
   input  logic                                        commit_kill_i,
   input  logic                                        result_valid_i,
   input  logic [ID_WIDTH-1:0]                         result_id_i,
   input  logic                                        flush_i,
   input  logic [REGFILE_NUM_READ_PORTS-1:0]           rf_re_id_i,
   input  logic [REGFILE_NUM_READ_PORTS*RF_ADDR_WIDTH-1:0] rf_raddr_id_i,
   input  logic                                        rf_we_id_i,
   input  logic [RF_ADDR_WIDTH-1:0]                    rd_id_i,
   output logic                                        stall_raw_o,
   output logic                                        stall_waw_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]        outstanding_cnt_o,
   output logic                                        empty_o
);

   localparam int CNT_W    = $clog2(MAX_OUTSTANDING+1);
   localparam int NUM_REGS = 1 << RF_ADDR_WIDTH;

   typedef struct packed {
      logic                     valid;
      logic [ID_WIDTH-1:0]      id;
      logic                     we;
      logic [RF_ADDR_WIDTH-1:0] rd;
      logic                     committed;
   } entry_t;

   entry_t                     tbl_q [MAX_OUTSTANDING];
   entry_t                     tbl_d [MAX_OUTSTANDING];
   logic [MAX_OUTSTANDING-1:0] alloc_oh;
   logic [MAX_OUTSTANDING-1:0] res_match;
   logic [MAX_OUTSTANDING-1:0] cmt_match;
   logic [MAX_OUTSTANDING-1:0] free_vec;
   logic [MAX_OUTSTANDING-1:0] dup_vec;
   logic                       full;
   logic                       issue_en;
   logic [NUM_REGS-1:0]        busy;
   logic [CNT_W-1:0]           cnt;

   // Lowest-index free entry; full is the AND of all valid bits once the loop ends.
   always_comb begin
      full     = 1'b1;
      alloc_oh = '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (!tbl_q[i].valid && full) begin
            alloc_oh[i] = 1'b1;
         end
         full = full & tbl_q[i].valid;
      end
   end

   assign issue_ready_o = !full;
   assign issue_en      = issue_valid_i && !full && !flush_i;

   always_comb begin
      tbl_d     = tbl_q;
      res_match = '0;
      cmt_match = '0;
      free_vec  = '0;
      dup_vec   = '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         res_match[i] = tbl_q[i].valid && result_valid_i && (tbl_q[i].id == result_id_i);
         cmt_match[i] = tbl_q[i].valid && commit_valid_i && (tbl_q[i].id == commit_id_i);
         dup_vec[i]   = tbl_q[i].valid && (tbl_q[i].id == issue_id_i);
         free_vec[i]  = res_match[i]
                      || (cmt_match[i] && commit_kill_i)
                      || (tbl_q[i].valid && flush_i && !tbl_q[i].committed);
         // Freeing wins over setting committed, so result+commit on one ID frees it.
         if (free_vec[i]) begin
            tbl_d[i] = '0;
         end else if (cmt_match[i] && !commit_kill_i) begin
            tbl_d[i].committed = 1'b1;
         end
         if (issue_en && alloc_oh[i]) begin
            tbl_d[i].valid     = 1'b1;
            tbl_d[i].id        = issue_id_i;
            tbl_d[i].we        = issue_we_i;
            tbl_d[i].rd        = issue_rd_i;
            tbl_d[i].committed = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            tbl_q[i] <= '0;
         end
      end else begin
         tbl_q <= tbl_d;
      end
   end

   // Per-register pending-write map; the in-flight issue is included so ID sees it the same cycle.
   always_comb begin
      busy = '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (tbl_q[i].valid && tbl_q[i].we) begin
            busy[tbl_q[i].rd] = 1'b1;
         end
      end
      if (issue_valid_i && issue_we_i && !flush_i) begin
         busy[issue_rd_i] = 1'b1;
      end
      busy[0] = 1'b0;
   end

   always_comb begin
      stall_raw_o = 1'b0;
      for (int p = 0; p < REGFILE_NUM_READ_PORTS; p++) begin
         if (rf_re_id_i[p] && busy[rf_raddr_id_i[p*RF_ADDR_WIDTH +: RF_ADDR_WIDTH]]) begin
            stall_raw_o = 1'b1;
         end
      end
      stall_waw_o = rf_we_id_i && busy[rd_id_i];
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         cnt = cnt + CNT_W'(tbl_q[i].valid);
      end
   end

   assign outstanding_cnt_o = cnt;
   assign empty_o           = (cnt == '0);

   a_issue_unique: assert property (@(posedge clk) disable iff (!rst_n)
      !(issue_valid_i && issue_ready_o && (|dup_vec)));
   a_result_match: assert property (@(posedge clk) disable iff (!rst_n)
      !(result_valid_i && !(|res_match)));

endmodule

// File: tb/tb_cv32e40x_wb_scoreboard.sv
// Bench for cv32e40x_wb_scoreboard: directed scenarios then random traffic against a queue-based model.
module tb_cv32e40x_wb_scoreboard;

   localparam int MAXO = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       issue_valid_i;
   logic [3:0] issue_id_i;
   logic       issue_we_i;
   logic [4:0] issue_rd_i;
   logic       issue_ready_o;
   logic       commit_valid_i;
   logic [3:0] commit_id_i;
   logic       commit_kill_i;
   logic       result_valid_i;
   logic [3:0] result_id_i;
   logic       flush_i;
   logic [1:0] rf_re_id_i;
   logic [9:0] rf_raddr_id_i;
   logic       rf_we_id_i;
   logic [4:0] rd_id_i;
   logic       stall_raw_o;
   logic       stall_waw_o;
   logic [2:0] outstanding_cnt_o;
   logic       empty_o;

   int n_chk = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] id;
      logic       we;
      logic [4:0] rd;
      bit         comm;
   } rec_t;

   rec_t mq[$];

   cv32e40x_wb_scoreboard #(
      .REGFILE_NUM_READ_PORTS(2), .MAX_OUTSTANDING(MAXO), .ID_WIDTH(4), .RF_ADDR_WIDTH(5)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid_i(issue_valid_i), .issue_id_i(issue_id_i), .issue_we_i(issue_we_i),
      .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
      .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
      .result_valid_i(result_valid_i), .result_id_i(result_id_i), .flush_i(flush_i),
      .rf_re_id_i(rf_re_id_i), .rf_raddr_id_i(rf_raddr_id_i), .rf_we_id_i(rf_we_id_i),
      .rd_id_i(rd_id_i), .stall_raw_o(stall_raw_o), .stall_waw_o(stall_waw_o),
      .outstanding_cnt_o(outstanding_cnt_o), .empty_o(empty_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
      end
   endtask

   function automatic bit m_hit(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      foreach (mq[k]) if (mq[k].we && mq[k].rd == a) return 1'b1;
      return issue_valid_i && issue_we_i && (issue_rd_i == a) && !flush_i;
   endfunction

   function automatic bit in_q(input logic [3:0] id);
      foreach (mq[k]) if (mq[k].id == id) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_all(input string tag);
      bit exp_raw;
      exp_raw = 1'b0;
      for (int p = 0; p < 2; p++)
         if (rf_re_id_i[p] && m_hit(rf_raddr_id_i[p*5 +: 5])) exp_raw = 1'b1;
      chk({tag, ".rdy"},   issue_ready_o,     (mq.size() < MAXO));
      chk({tag, ".cnt"},   outstanding_cnt_o, mq.size());
      chk({tag, ".empty"}, empty_o,           (mq.size() == 0));
      chk({tag, ".raw"},   stall_raw_o,       exp_raw);
      chk({tag, ".waw"},   stall_waw_o,       (rf_we_id_i && m_hit(rd_id_i)));
   endtask

   // Table as an unordered set: slot placement is invisible at the ports.
   task automatic model_edge();
      rec_t nq[$];
      bit   rdy;
      rdy = (mq.size() < MAXO);
      foreach (mq[k]) begin
         rec_t r;
         bit   gone;
         r    = mq[k];
         gone = (result_valid_i && r.id == result_id_i)
              || (commit_valid_i && commit_kill_i && r.id == commit_id_i)
              || (flush_i && !r.comm);
         if (!gone) begin
            if (commit_valid_i && !commit_kill_i && r.id == commit_id_i) r.comm = 1'b1;
            nq.push_back(r);
         end
      end
      if (issue_valid_i && rdy && !flush_i)
         nq.push_back('{id: issue_id_i, we: issue_we_i, rd: issue_rd_i, comm: 1'b0});
      mq = nq;
   endtask

   task automatic idle();
      issue_valid_i = 0; issue_id_i = 0; issue_we_i = 0; issue_rd_i = 0;
      commit_valid_i = 0; commit_id_i = 0; commit_kill_i = 0;
      result_valid_i = 0; result_id_i = 0; flush_i = 0;
      rf_re_id_i = 0; rf_raddr_id_i = 0; rf_we_id_i = 0; rd_id_i = 0;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      idle();
   endtask

   task automatic issue(input logic [3:0] id, input logic we, input logic [4:0] rd);
      issue_valid_i = 1; issue_id_i = id; issue_we_i = we; issue_rd_i = rd;
   endtask

   task automatic result(input logic [3:0] id);
      result_valid_i = 1; result_id_i = id;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.rdy", issue_ready_o, 1); chk("rst.empty", empty_o, 1);
      chk("rst.cnt", outstanding_cnt_o, 0);
      chk("rst.raw", stall_raw_o, 0); chk("rst.waw", stall_waw_o, 0);
      rst_n = 1'b1;

      // Issue bypass and release one cycle after the result.
      issue(3, 1, 5); rf_re_id_i = 2'b10; rf_raddr_id_i = {5'd5, 5'd0};
      #1 check_all("bypass"); chk("bypass.raw1", stall_raw_o, 1); step();
      rf_re_id_i = 2'b10; rf_raddr_id_i = {5'd5, 5'd0};
      #1 check_all("held"); chk("held.raw1", stall_raw_o, 1); step();
      result(3); rf_re_id_i = 2'b10; rf_raddr_id_i = {5'd5, 5'd0};
      #1 check_all("res_cyc"); chk("res_cyc.raw1", stall_raw_o, 1); step();
      rf_re_id_i = 2'b10; rf_raddr_id_i = {5'd5, 5'd0};
      #1 check_all("released"); chk("released.raw0", stall_raw_o, 0);
      chk("released.cnt0", outstanding_cnt_o, 0); step();

      // Fill, then result + issue while full: the issue is dropped.
      for (int k = 0; k < MAXO; k++) begin
         issue(4'(4 + k), 1, 5'(8 + k));
         #1 check_all("fill"); step();
      end
      #1 chk("full.rdy0", issue_ready_o, 0); chk("full.cnt4", outstanding_cnt_o, 4);
      result(4); issue(8, 1, 12);
      #1 check_all("full_iss"); step();
      #1 chk("after.rdy1", issue_ready_o, 1); chk("after.cnt3", outstanding_cnt_o, 3);
      for (int k = 5; k < 8; k++) begin
         result(4'(k)); #1 check_all("drain"); step();
      end

      // Commit one, flush: committed entry survives and still blocks WAW.
      issue(1, 1, 6); #1 check_all("i1"); step();
      issue(2, 1, 7); #1 check_all("i2"); step();
      commit_valid_i = 1; commit_id_i = 1; #1 check_all("cmt1"); step();
      flush_i = 1; #1 check_all("flush"); step();
      #1 chk("flush.cnt1", outstanding_cnt_o, 1);
      rf_we_id_i = 1; rd_id_i = 6;
      #1 check_all("waw6"); chk("waw6.waw1", stall_waw_o, 1); step();

      // Kill frees the entry; x0 writes never stall.
      issue(2, 1, 7); #1 check_all("i2b"); step();
      rf_re_id_i = 2'b01; rf_raddr_id_i = {5'd0, 5'd7};
      commit_valid_i = 1; commit_id_i = 2; commit_kill_i = 1;
      #1 check_all("kill"); chk("kill.raw1", stall_raw_o, 1); step();
      rf_re_id_i = 2'b01; rf_raddr_id_i = {5'd0, 5'd7};
      #1 check_all("killed"); chk("killed.raw0", stall_raw_o, 0); step();
      issue(9, 1, 0); rf_re_id_i = 2'b11; rf_raddr_id_i = 10'd0; rf_we_id_i = 1; rd_id_i = 0;
      #1 check_all("x0a"); chk("x0a.raw0", stall_raw_o, 0); step();
      rf_re_id_i = 2'b11; rf_raddr_id_i = 10'd0; rf_we_id_i = 1; rd_id_i = 0;
      #1 check_all("x0b"); chk("x0b.waw0", stall_waw_o, 0); step();
      result(1); #1 check_all("cl1"); step();
      result(9); #1 check_all("cl9"); step();

      // Asynchronous reset with three entries live.
      for (int k = 0; k < 3; k++) begin
         issue(4'(10 + k), 1, 5'(13 + k)); #1 check_all("pre_ar"); step();
      end
      rf_re_id_i = 2'b01; rf_raddr_id_i = {5'd0, 5'd13}; rf_we_id_i = 1; rd_id_i = 14;
      #1 check_all("pre_ar2"); chk("pre_ar2.cnt3", outstanding_cnt_o, 3);
      #2 rst_n = 1'b0;
      #1 chk("ar.rdy", issue_ready_o, 1); chk("ar.cnt", outstanding_cnt_o, 0);
      chk("ar.empty", empty_o, 1); chk("ar.raw", stall_raw_o, 0); chk("ar.waw", stall_waw_o, 0);
      mq.delete();
      @(negedge clk);
      idle();
      rst_n = 1'b1;

      // Random traffic.
      for (int cyc = 0; cyc < 600; cyc++) begin
         if ($urandom_range(0, 1) == 1) begin
            logic [3:0] nid;
            do nid = 4'($urandom_range(0, 15)); while (in_q(nid));
            issue(nid, ($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)));
         end
         if (mq.size() > 0 && $urandom_range(0, 9) < 3)
            result(mq[$urandom_range(0, mq.size() - 1)].id);
         if ($urandom_range(0, 3) == 0) begin
            commit_valid_i = 1;
            commit_kill_i  = ($urandom_range(0, 9) < 3);
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
               commit_id_i = mq[$urandom_range(0, mq.size() - 1)].id;
            else
               commit_id_i = 4'($urandom_range(0, 15));
         end
         flush_i       = ($urandom_range(0, 19) == 0);
         rf_re_id_i    = 2'($urandom_range(0, 3));
         rf_raddr_id_i = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         rf_we_id_i    = 1'($urandom_range(0, 1));
         rd_id_i       = 5'($urandom_range(0, 7));
         #1 check_all("rnd");
         step();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
